// File: rtl/trap_ctrl.sv
// Trap initiator for the M-mode CSR file: selects exceptions, mret and the external interrupt,
// pulses the CSR trap-update inputs and redirects fetch. Optional macro: TRAP_VECTORED_EN.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned INT_CODE    = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic        exc_illegal,
  input  logic        exc_ecall,
  input  logic        exc_lfault,
  input  logic        exc_sfault,
  input  logic        is_mret_wb,
  input  logic        ext_int,
  input  logic [31:0] pc_wb,
  input  logic [31:0] inst_wb,
  input  logic [31:0] fault_addr,
  input  logic [31:0] mstatus,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_i,
  output logic        wb_kill,
  output logic        is_trap,
  output logic        is_mret,
  output logic [31:0] mepc,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_all,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIR} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   int_pend;
  logic                   exc_any;
  logic                   eval;
  logic                   trap_sel;
  logic                   mret_sel;
  logic [31:0]            cause_sel;
  logic [31:0]            tval_sel;
  logic [31:0]            base;
  logic [31:0]            target;
  logic                   unused_ok;

  assign int_pend = sync[SYNC_STAGES-1] & mstatus[3];
  assign exc_any  = exc_illegal | exc_ecall | exc_lfault | exc_sfault;
  assign eval     = (state == IDLE) & wb_valid;
  // mret outranks the interrupt, so an interrupt only traps when no mret is present
  assign trap_sel = eval & (exc_any | (~is_mret_wb & int_pend));
  assign mret_sel = eval & ~exc_any & is_mret_wb;
  assign wb_kill  = trap_sel;
  assign busy     = (state != IDLE);
  assign base     = {mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // mcause[31] still marks the trap kind while in TRAP
  assign target    = ((mtvec[1:0] == 2'b01) && mcause[31]) ? base + 32'(INT_CODE * 4) : base;
  assign unused_ok = ^{mstatus[31:4], mstatus[2:0]};
`else
  assign target    = base;
  assign unused_ok = ^{mstatus[31:4], mstatus[2:0], mtvec[1:0]};
`endif

  // Cause and trap value, highest-priority exception first
  always_comb begin
    cause_sel = {1'b1, 31'(INT_CODE)};
    tval_sel  = 32'd0;
    if (exc_illegal) begin
      cause_sel = 32'd2;
      tval_sel  = inst_wb;
    end else if (exc_ecall) begin
      cause_sel = 32'd11;
    end else if (exc_lfault) begin
      cause_sel = 32'd5;
      tval_sel  = fault_addr;
    end else if (exc_sfault) begin
      cause_sel = 32'd7;
      tval_sel  = fault_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sync        <= '0;
      is_trap     <= 1'b0;
      is_mret     <= 1'b0;
      mepc        <= 32'd0;
      mcause      <= 32'd0;
      mtval       <= 32'd0;
      redirect    <= 1'b0;
      redirect_pc <= 32'd0;
      flush_all   <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ext_int};
      case (state)
        IDLE: begin
          if (trap_sel) begin
            state     <= TRAP;
            is_trap   <= 1'b1;
            flush_all <= 1'b1;
            mepc      <= pc_wb;
            mcause    <= cause_sel;
            mtval     <= tval_sel;
          end else if (mret_sel) begin
            state     <= MRET;
            is_mret   <= 1'b1;
            flush_all <= 1'b1;
            mepc      <= mepc_i;
          end
        end
        TRAP: begin
          state       <= REDIR;
          is_trap     <= 1'b0;
          redirect    <= 1'b1;
          redirect_pc <= target;
        end
        MRET: begin
          state       <= REDIR;
          is_mret     <= 1'b0;
          redirect    <= 1'b1;
          redirect_pc <= mepc_i;
        end
        default: begin
          state     <= IDLE;
          redirect  <= 1'b0;
          flush_all <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: table of single-event transactions plus interrupt and
// mid-sequence reset sequences.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, exc_illegal, exc_ecall, exc_lfault, exc_sfault, is_mret_wb, ext_int;
  logic [31:0] pc_wb, inst_wb, fault_addr, mstatus, mtvec, mepc_i;
  logic        wb_kill, is_trap, is_mret, redirect, flush_all, busy;
  logic [31:0] mepc, mcause, mtval, redirect_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .exc_illegal(exc_illegal),
    .exc_ecall(exc_ecall), .exc_lfault(exc_lfault), .exc_sfault(exc_sfault),
    .is_mret_wb(is_mret_wb), .ext_int(ext_int), .pc_wb(pc_wb), .inst_wb(inst_wb),
    .fault_addr(fault_addr), .mstatus(mstatus), .mtvec(mtvec), .mepc_i(mepc_i),
    .wb_kill(wb_kill), .is_trap(is_trap), .is_mret(is_mret), .mepc(mepc),
    .mcause(mcause), .mtval(mtval), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush_all(flush_all), .busy(busy)
  );

  typedef struct {
    logic        valid, ill, ecall, lf, sf, mret;
    logic [31:0] pc, inst, faddr, tvec, epc_in;
    logic [1:0]  evt;   // 0 none, 1 trap, 2 mret
    logic        kill;
    logic [31:0] cause, tval, epc, rpc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wb();
    wb_valid = 0; exc_illegal = 0; exc_ecall = 0; exc_lfault = 0; exc_sfault = 0;
    is_mret_wb = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_wb();
    ext_int = 0; pc_wb = 0; inst_wb = 0; fault_addr = 0; mstatus = 0; mtvec = 0; mepc_i = 0;
    rst = 1;
    #1;
    chk("reset is_trap", 32'(is_trap), 0);
    chk("reset redirect_pc", redirect_pc, 0);
    chk("reset mcause", mcause, 0);
    chk("reset flush_all", 32'(flush_all), 0);
    chk("reset busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    //          valid ill ec lf sf mret pc          inst          faddr         tvec          epc_in        evt kill cause  tval          epc           rpc
    vecs[0] = '{1, 1, 0, 0, 0, 0, 32'h100, 32'hFFFFFFFF, 32'h0,        32'h200, 32'h0,   1, 1, 32'd2,  32'hFFFFFFFF, 32'h100, 32'h200};
    vecs[1] = '{1, 0, 1, 1, 0, 0, 32'h104, 32'h13,       32'h80000004, 32'h201, 32'h0,   1, 1, 32'd11, 32'h0,        32'h104, 32'h200};
    vecs[2] = '{1, 0, 0, 1, 0, 0, 32'h108, 32'h13,       32'h80000004, 32'h300, 32'h0,   1, 1, 32'd5,  32'h80000004, 32'h108, 32'h300};
    vecs[3] = '{1, 0, 0, 0, 1, 0, 32'h10C, 32'h13,       32'h1234,     32'h303, 32'h0,   1, 1, 32'd7,  32'h1234,     32'h10C, 32'h300};
    vecs[4] = '{1, 0, 0, 0, 1, 1, 32'h110, 32'h13,       32'h55,       32'h200, 32'h0,   1, 1, 32'd7,  32'h55,       32'h110, 32'h200};
    vecs[5] = '{1, 0, 0, 0, 0, 1, 32'h114, 32'h30200073, 32'h0,        32'h200, 32'h104, 2, 0, 32'd7,  32'h55,       32'h104, 32'h104};
    vecs[6] = '{0, 1, 0, 0, 0, 0, 32'h118, 32'hDEAD,     32'h0,        32'h200, 32'h0,   0, 0, 32'd7,  32'h55,       32'h104, 32'h104};

    for (int i = 0; i < 7; i++) begin
      wb_valid = vecs[i].valid; exc_illegal = vecs[i].ill; exc_ecall = vecs[i].ecall;
      exc_lfault = vecs[i].lf; exc_sfault = vecs[i].sf; is_mret_wb = vecs[i].mret;
      pc_wb = vecs[i].pc; inst_wb = vecs[i].inst; fault_addr = vecs[i].faddr;
      mtvec = vecs[i].tvec; mepc_i = vecs[i].epc_in;
      #1 chk($sformatf("v%0d wb_kill", i), 32'(wb_kill), 32'(vecs[i].kill));
      tick();
      clear_wb();
      chk($sformatf("v%0d is_trap", i), 32'(is_trap), 32'(vecs[i].evt == 2'd1));
      chk($sformatf("v%0d is_mret", i), 32'(is_mret), 32'(vecs[i].evt == 2'd2));
      chk($sformatf("v%0d mcause", i), mcause, vecs[i].cause);
      chk($sformatf("v%0d mtval", i), mtval, vecs[i].tval);
      chk($sformatf("v%0d mepc", i), mepc, vecs[i].epc);
      if (vecs[i].evt != 2'd0) begin
        chk($sformatf("v%0d flush_trap", i), 32'(flush_all), 1);
        chk($sformatf("v%0d wb_kill_busy", i), 32'(wb_kill), 0);
        tick();
        chk($sformatf("v%0d redirect", i), 32'(redirect), 1);
        chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
        chk($sformatf("v%0d flush_redir", i), 32'(flush_all), 1);
        tick();
      end
      chk($sformatf("v%0d idle redirect", i), 32'(redirect), 0);
      chk($sformatf("v%0d idle busy", i), 32'(busy), 0);
      chk($sformatf("v%0d idle flush", i), 32'(flush_all), 0);
    end

    // External interrupt through the synchroniser, vectored when enabled
    wb_valid = 1; pc_wb = 32'h40; mstatus = 32'h88; mtvec = 32'h201; ext_int = 1;
    #1 chk("int before sync", 32'(wb_kill), 0);
    tick();
    chk("int sync1 kill", 32'(wb_kill), 0);
    tick();
    chk("int sync2 kill", 32'(wb_kill), 1);
    tick();
    mstatus = 32'h80;
    chk("int is_trap", 32'(is_trap), 1);
    chk("int mcause", mcause, 32'h8000000B);
    chk("int mepc", mepc, 32'h40);
    chk("int mtval", mtval, 32'h0);
    tick();
    chk("int redirect", 32'(redirect), 1);
`ifdef TRAP_VECTORED_EN
    chk("int redirect_pc", redirect_pc, 32'h22C);
`else
    chk("int redirect_pc", redirect_pc, 32'h200);
`endif
    tick();
    chk("int masked kill", 32'(wb_kill), 0);
    tick();
    chk("int masked is_trap", 32'(is_trap), 0);
    chk("int masked busy", 32'(busy), 0);
    ext_int = 0; clear_wb();
    repeat (3) tick();

    // Reset while in TRAP aborts the sequence
    wb_valid = 1; exc_illegal = 1; pc_wb = 32'h300; inst_wb = 32'h1; mtvec = 32'h400;
    tick();
    clear_wb();
    chk("rst pre is_trap", 32'(is_trap), 1);
    #1 rst = 1;
    #1;
    chk("rst is_trap", 32'(is_trap), 0);
    chk("rst flush", 32'(flush_all), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst mcause", mcause, 0);
    chk("rst mepc", mepc, 0);
    tick();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rst no redirect c%0d", c), 32'(redirect), 0);
      chk($sformatf("rst no busy c%0d", c), 32'(busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
